// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the EX stage of the five-stage MIPS pipeline.
// Executes mult/multu/div/divu with a fixed multi-cycle latency and mthi/mtlo in
// one cycle, and holds the architectural HI/LO registers.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   A, B   forwarded rs / rt operands
//   MDOp   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   start  EX-stage instruction is an md op (qualifies MDOp)
//   kill   EX-stage instruction is flushed this cycle
//   busy   multi-cycle operation in flight
//   HI, LO committed HI/LO registers
module md_unit #(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        MDOp,
    input  logic              start,
    input  logic              kill,
    output logic              busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;
    logic              accept;
    logic [2*DATA_W-1:0] mul_w;
    logic [2*DATA_W-1:0] div_w;

    // Full double-width product; operands are extended according to signedness
    // so the low 2*DATA_W bits of the product are correct in both modes.
    function automatic logic [2*DATA_W-1:0] mul_res(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic sgn);
        logic signed [2*DATA_W-1:0] pa;
        logic signed [2*DATA_W-1:0] pb;
        pa = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        pb = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        return pa * pb;
    endfunction

    // Returns {remainder, quotient}. Divide-by-zero and the single signed
    // overflow case are resolved explicitly so the result is fully defined.
    function automatic logic [2*DATA_W-1:0] div_res(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic sgn);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [DATA_W-1:0]        q;
        logic [DATA_W-1:0]        r;
        sa = a;
        sb = b;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn && a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    assign accept = start && !kill && !busy;

    always_comb begin
        mul_w = mul_res(A, B, MDOp == 3'd1);
        div_w = div_res(A, B, MDOp == 3'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (MDOp)
                            3'd1, 3'd2: begin
                                {res_hi, res_lo} <= mul_w;
                                cnt   <= CW'(MULT_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            3'd3, 3'd4: begin
                                {res_hi, res_lo} <= div_w;
                                cnt   <= CW'(DIV_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            3'd5:    HI <= A;
                            3'd6:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Commit on the edge where the counter would reach zero.
                    if (cnt == CW'(1)) begin
                        HI    <= res_hi;
                        LO    <= res_lo;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A, B;
    logic [2:0]  MDOp;
    logic        start, kill;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    // Reference model state: committed values plus one pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;   // cycles until the pending result commits, 0 = idle

    md_unit #(.DATA_W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDOp(MDOp),
        .start(start), .kill(kill), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result {HI, LO} from plain 64-bit integer arithmetic.
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [63:0]     t;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        t  = '0;
        case (op)
            3'd1: begin sp = sa * sb; t = sp; end
            3'd2: begin up = ua * ub; t = up; end
            3'd3: begin
                if (b == 0) t = {a, 32'hFFFFFFFF};
                else begin
                    sp = sa % sb;
                    t[63:32] = sp[31:0];
                    sp = sa / sb;
                    t[31:0] = sp[31:0];
                end
            end
            3'd4: begin
                if (b == 0) t = {a, 32'hFFFFFFFF};
                else begin
                    up = ua % ub;
                    t[63:32] = up[31:0];
                    up = ua / ub;
                    t[31:0] = up[31:0];
                end
            end
            default: t = '0;
        endcase
        return t;
    endfunction

    task automatic model_edge(input logic st, input logic kl, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (st && !kl) begin
            r = ref_res(op, a, b);
            if (op == 3'd1 || op == 3'd2) begin
                {p_hi, p_lo} = r;
                m_left = 5;
            end else if (op == 3'd3 || op == 3'd4) begin
                {p_hi, p_lo} = r;
                m_left = 10;
            end else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0;
    endtask

    // One clock: drive inputs, take the edge, then compare 1 ns later.
    task automatic cyc(input logic st, input logic kl, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        start = st; kill = kl; MDOp = op; A = a; B = b;
        @(posedge clk);
        model_edge(st, kl, op, a, b);
        #1;
        chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy);
        cyc(1'b1, 1'b0, op, a, b);
        nbusy = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            nbusy++;
            cyc(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        end
    endtask

    int nb;
    logic [31:0] ra, rb;

    initial begin
        model_reset();
        rst_n = 1'b0; start = 0; kill = 0; MDOp = 0; A = 0; B = 0;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // mult / multu
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, nb);
        chk("mult_nbusy", nb, 32'd5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, nb);
        chk("multu_nbusy", nb, 32'd5);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        // div / divu
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, nb);
        chk("div_nbusy", nb, 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);
        run_op(3'd4, 32'd7, 32'd0, nb);
        chk("divu0_hi", HI, 32'd7);
        chk("divu0_lo", LO, 32'hFFFFFFFF);

        // mthi then mtlo back to back
        run_op(3'd5, 32'h12345678, 32'h0, nb);
        chk("mthi_nbusy", nb, 32'd0);
        cyc(1, 0, 3'd6, 32'h9ABCDEF0, 32'h0);
        chk("mthi_hi", HI, 32'h12345678);
        chk("mtlo_lo", LO, 32'h9ABCDEF0);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);

        // kill suppresses acceptance
        cyc(1, 1, 3'd1, 32'd3, 32'd4);
        chk("kill_busy", {31'b0, busy}, 32'd0);
        chk("kill_hi", HI, 32'h12345678);

        // mtlo while busy is ignored
        cyc(1, 0, 3'd1, 32'd3, 32'd4);
        cyc(1, 0, 3'd6, 32'hDEADBEEF, 32'h0);
        for (int i = 0; i < 30 && busy; i++) cyc(0, 0, 0, 0, 0);
        chk("mtlo_busy_lo", LO, 32'd12);
        chk("mtlo_busy_hi", HI, 32'd0);

        // signed overflow
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, nb);
        chk("ovf_lo", LO, 32'h80000000);
        chk("ovf_hi", HI, 32'h0);

        // asynchronous reset two cycles into a mult
        cyc(1, 0, 3'd1, 32'h7, 32'h9);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("amid_busy", {31'b0, busy}, 32'd0);
        chk("amid_hi", HI, 32'd0);
        chk("amid_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
        chk("post_rst_lo", LO, 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                3'($urandom_range(0, 7)), ra, rb);
        end
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
